// File: rtl/finder_center_locator.sv
// Finder-pattern center locator: scans a grid of zones and reports the centers of zones whose black ratio meets a threshold.
// Latency: 1 cycle per non-candidate pixel, 1+READ_LATENCY per candidate pixel, 1 per zone evaluation, then a 1-cycle DONE.
// Backpressure: none; start_in is ignored while busy_out, and the frame buffer must answer READ_LATENCY cycles after the address.
//
// Ports: clk_in/rst_n_in (async active-low), start_in, horz_patterns/vert_patterns (candidate column/row flags),
//   bound_x/bound_y (ascending zone split points), pixel_reading/address_reading (frame-buffer read, 1 = white),
//   centers_x/centers_y/centers_count (results), busy_out, centers_valid, centers_not_found_error (one-cycle pulses).
// Optional macro FINDER_MIDPOINT_EN: center is the midpoint of the candidate bounding box instead of the first candidate.
module finder_center_locator #(
  parameter int WIDTH        = 480,
  parameter int HEIGHT       = 480,
  parameter int ZONES_X      = 3,
  parameter int ZONES_Y      = 3,
  parameter int NUM_CENTERS  = 3,
  parameter int READ_LATENCY = 2,
  parameter int BLACK_Q      = 3,
  localparam int CW  = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT),
  localparam int AW  = $clog2(WIDTH * HEIGHT),
  localparam int NW  = $clog2(WIDTH * HEIGHT + 1),
  localparam int BXN = (ZONES_X > 1) ? ZONES_X - 1 : 1,
  localparam int BYN = (ZONES_Y > 1) ? ZONES_Y - 1 : 1,
  localparam int KW  = $clog2(NUM_CENTERS + 1)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic [WIDTH-1:0]          horz_patterns,
  input  logic [HEIGHT-1:0]         vert_patterns,
  input  logic [CW*BXN-1:0]         bound_x,
  input  logic [CW*BYN-1:0]         bound_y,
  input  logic                      pixel_reading,
  output logic [AW-1:0]             address_reading,
  output logic [CW*NUM_CENTERS-1:0] centers_x,
  output logic [CW*NUM_CENTERS-1:0] centers_y,
  output logic [KW-1:0]             centers_count,
  output logic                      busy_out,
  output logic                      centers_valid,
  output logic                      centers_not_found_error
);

  localparam int ZMAX = (ZONES_X > ZONES_Y) ? ZONES_X : ZONES_Y;
  localparam int BMW  = CW * ((ZMAX > 1) ? ZMAX - 1 : 1);
  localparam int ZXW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int ZYW  = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
  localparam int WCW  = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_EVAL, S_DONE} state_t;
  state_t state, state_nxt;

  // Both bound buses padded to one width so a single pair of helpers serves both axes.
  function automatic logic [CW:0] zone_lo(input logic [BMW-1:0] b, input int z);
    zone_lo = '0;
    for (int i = 0; i < ZMAX - 1; i++)
      if (z == i + 1) zone_lo = {1'b0, b[i*CW +: CW]};
  endfunction

  function automatic logic [CW:0] zone_hi(input logic [BMW-1:0] b, input int z, input int nz, input int full);
    zone_hi = (CW+1)'(full);
    for (int i = 0; i < ZMAX - 1; i++)
      if (z == i && i < nz - 1) zone_hi = {1'b0, b[i*CW +: CW]};
  endfunction

  logic [BMW-1:0]  bx_pad, by_pad;
  logic [ZXW-1:0]  zx, nzx;
  logic [ZYW-1:0]  zy, nzy;
  logic [CW:0]     x, y, x_p1, y_p1, lo_x, hi_x, lo_y, hi_y;
  logic [WCW-1:0]  wait_cnt;
  logic [NW-1:0]   black, white;
  logic [NW+2:0]   tot_w;
  logic [CW-1:0]   cen_x, cen_y;
  logic            zone_empty, cand, row_end, zone_end, last_x, last_zone, accept, full_after;
  logic            begin_scan, to_wait, adv, sample, store, load_zone, fire_valid, fire_err;
  int              addr_full;

`ifdef FINDER_MIDPOINT_EN
  logic [CW-1:0]   min_x, min_y, max_x, max_y;
  logic [CW:0]     sum_x, sum_y;
`else
  logic [CW-1:0]   first_x, first_y;
`endif

  assign bx_pad   = BMW'(bound_x);
  assign by_pad   = BMW'(bound_y);
  assign busy_out = (state == S_SCAN) || (state == S_WAIT) || (state == S_EVAL);

  always_comb begin
    lo_x       = zone_lo(bx_pad, int'(zx));
    hi_x       = zone_hi(bx_pad, int'(zx), ZONES_X, WIDTH);
    lo_y       = zone_lo(by_pad, int'(zy));
    hi_y       = zone_hi(by_pad, int'(zy), ZONES_Y, HEIGHT);
    zone_empty = (lo_x >= hi_x) || (lo_y >= hi_y);
    last_x     = (int'(zx) == ZONES_X - 1);
    last_zone  = last_x && (int'(zy) == ZONES_Y - 1);
    nzx        = last_x ? '0 : zx + ZXW'(1);
    nzy        = last_x ? zy + ZYW'(1) : zy;
    cand       = |(horz_patterns & (WIDTH'(1) << x)) && |(vert_patterns & (HEIGHT'(1) << y));
    x_p1       = x + (CW+1)'(1);
    y_p1       = y + (CW+1)'(1);
    row_end    = (x_p1 >= hi_x);
    zone_end   = row_end && (y_p1 >= hi_y);
    addr_full  = 32'(x) + 32'(y) * WIDTH;
    // Threshold compare widened so neither side can truncate.
    tot_w      = (NW+3)'(black) + (NW+3)'(white);
    accept     = (tot_w != '0) && (((NW+3)'(black) << 2) >= tot_w * (NW+3)'(BLACK_Q));
    full_after = accept && (int'(centers_count) == NUM_CENTERS - 1);
`ifdef FINDER_MIDPOINT_EN
    sum_x      = (CW+1)'(min_x) + (CW+1)'(max_x);
    sum_y      = (CW+1)'(min_y) + (CW+1)'(max_y);
    cen_x      = CW'(sum_x >> 1);
    cen_y      = CW'(sum_y >> 1);
`else
    cen_x      = first_x;
    cen_y      = first_y;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    begin_scan = 1'b0;
    to_wait    = 1'b0;
    adv        = 1'b0;
    sample     = 1'b0;
    store      = 1'b0;
    load_zone  = 1'b0;
    fire_valid = 1'b0;
    fire_err   = 1'b0;
    case (state)
      S_IDLE: if (start_in) begin
        begin_scan = 1'b1;
        state_nxt  = S_SCAN;
      end
      S_SCAN: begin
        if (zone_empty)    state_nxt = S_EVAL;
        else if (cand)     begin to_wait = 1'b1; state_nxt = S_WAIT; end
        else if (zone_end) state_nxt = S_EVAL;
        else               adv = 1'b1;
      end
      S_WAIT: if (int'(wait_cnt) == READ_LATENCY - 1) begin
        sample = 1'b1;
        if (zone_end) state_nxt = S_EVAL;
        else begin adv = 1'b1; state_nxt = S_SCAN; end
      end
      S_EVAL: begin
        store = accept;
        if (full_after)     begin fire_valid = 1'b1; state_nxt = S_DONE; end
        else if (last_zone) begin fire_err = 1'b1; state_nxt = S_DONE; end
        else                begin load_zone = 1'b1; state_nxt = S_SCAN; end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      zx <= '0; zy <= '0; x <= '0; y <= '0; wait_cnt <= '0;
      black <= '0; white <= '0;
      address_reading <= '0;
      centers_x <= '0; centers_y <= '0; centers_count <= '0;
      centers_valid <= 1'b0; centers_not_found_error <= 1'b0;
`ifdef FINDER_MIDPOINT_EN
      min_x <= '0; min_y <= '0; max_x <= '0; max_y <= '0;
`else
      first_x <= '0; first_y <= '0;
`endif
    end else begin
      centers_valid           <= fire_valid;
      centers_not_found_error <= fire_err;
      if (begin_scan || load_zone) begin
        black <= '0;
        white <= '0;
      end
      if (begin_scan) begin
        zx <= '0; zy <= '0; x <= '0; y <= '0;
        centers_x <= '0; centers_y <= '0; centers_count <= '0;
      end
      if (to_wait) begin
        address_reading <= AW'(addr_full);
        wait_cnt        <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
      if (adv) begin
        if (row_end) begin x <= lo_x; y <= y_p1; end
        else         x <= x_p1;
      end
      if (sample) begin
        if (pixel_reading) white <= white + NW'(1);
        else               black <= black + NW'(1);
        // Counts are still zero on the first candidate of a zone.
`ifdef FINDER_MIDPOINT_EN
        if (tot_w == '0) begin
          min_x <= x[CW-1:0]; max_x <= x[CW-1:0];
          min_y <= y[CW-1:0]; max_y <= y[CW-1:0];
        end else begin
          if (x[CW-1:0] < min_x) min_x <= x[CW-1:0];
          if (x[CW-1:0] > max_x) max_x <= x[CW-1:0];
          if (y[CW-1:0] < min_y) min_y <= y[CW-1:0];
          if (y[CW-1:0] > max_y) max_y <= y[CW-1:0];
        end
`else
        if (tot_w == '0) begin
          first_x <= x[CW-1:0];
          first_y <= y[CW-1:0];
        end
`endif
      end
      if (store) begin
        for (int i = 0; i < NUM_CENTERS; i++) begin
          if (int'(centers_count) == i) begin
            centers_x[i*CW +: CW] <= cen_x;
            centers_y[i*CW +: CW] <= cen_y;
          end
        end
        centers_count <= centers_count + KW'(1);
      end
      if (load_zone) begin
        zx <= nzx;
        zy <= nzy;
        x  <= zone_lo(bx_pad, int'(nzx));
        y  <= zone_lo(by_pad, int'(nzy));
      end
    end
  end

endmodule

// File: tb/tb_finder_center_locator.sv
// Bench for finder_center_locator on a reduced 24x20 frame with a 3x3 zone grid.
// A zone-by-zone reference model predicts centers, outcome and exact busy length for each run.
// Directed cases carry hand-computed literals; random frames, flags and bounds follow.
module tb_finder_center_locator;
  localparam int W = 24, H = 20, ZX = 3, ZY = 3, NC = 3, RL = 2, BQ = 3;
  localparam int CW = 5, AW = 9, KW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] hf = '0;
  logic [H-1:0] vf = '0;
  logic [CW*2-1:0] bxv, byv;
  logic pix_q = 1'b1;
  logic [AW-1:0] address_reading;
  logic [CW*NC-1:0] centers_x, centers_y;
  logic [KW-1:0] centers_count;
  logic busy_out, centers_valid, centers_not_found_error;

  bit frame [W*H];
  int bxs[2], bys[2];
  int n_cmp = 0, n_bad = 0;

  int exp_cyc, exp_cnt;
  bit exp_ok;
  logic [CW*NC-1:0] exp_cx, exp_cy;
  int got_busy, got_cnt;
  bit got_err;
  logic [CW*NC-1:0] got_cx, got_cy;

  finder_center_locator #(
    .WIDTH(W), .HEIGHT(H), .ZONES_X(ZX), .ZONES_Y(ZY),
    .NUM_CENTERS(NC), .READ_LATENCY(RL), .BLACK_Q(BQ)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .horz_patterns(hf), .vert_patterns(vf),
    .bound_x(bxv), .bound_y(byv),
    .pixel_reading(pix_q), .address_reading(address_reading),
    .centers_x(centers_x), .centers_y(centers_y), .centers_count(centers_count),
    .busy_out(busy_out), .centers_valid(centers_valid),
    .centers_not_found_error(centers_not_found_error)
  );

  always #5 clk = ~clk;

  // Frame buffer with one register stage: data follows the address by READ_LATENCY=2 cycles.
  always @(posedge clk) pix_q <= frame[address_reading];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic set_bounds(input int a0, input int a1, input int b0, input int b1);
    bxs[0] = a0; bxs[1] = a1; bys[0] = b0; bys[1] = b1;
    bxv = {a1[CW-1:0], a0[CW-1:0]};
    byv = {b1[CW-1:0], b0[CW-1:0]};
  endtask

  task automatic clear_all();
    hf = '0; vf = '0;
    for (int i = 0; i < W*H; i++) frame[i] = 1'b1;
  endtask

  // Walks zones in row-major order and pixels in raster order, applying the acceptance rule directly.
  task automatic model();
    int lox, hix, loy, hiy, blk, wht, fx, fy, mnx, mny, mxx, mxy, cx, cy;
    bit fin;
    exp_cyc = 0; exp_cnt = 0; exp_ok = 0; exp_cx = '0; exp_cy = '0; fin = 0;
    for (int zy = 0; zy < ZY && !fin; zy++) begin
      for (int zx = 0; zx < ZX && !fin; zx++) begin
        lox = 0; hix = W; loy = 0; hiy = H;
        if (zx > 0) lox = bxs[zx-1];
        if (zx < ZX-1) hix = bxs[zx];
        if (zy > 0) loy = bys[zy-1];
        if (zy < ZY-1) hiy = bys[zy];
        blk = 0; wht = 0; fx = -1; fy = -1; mnx = W; mny = H; mxx = 0; mxy = 0;
        if (lox >= hix || loy >= hiy) begin
          exp_cyc += 2;
        end else begin
          for (int yy = loy; yy < hiy; yy++) begin
            for (int xx = lox; xx < hix; xx++) begin
              exp_cyc++;
              if (hf[xx] && vf[yy]) begin
                exp_cyc += RL;
                if (frame[yy*W+xx]) wht++; else blk++;
                if (fx < 0) begin fx = xx; fy = yy; end
                if (xx < mnx) mnx = xx;
                if (xx > mxx) mxx = xx;
                if (yy < mny) mny = yy;
                if (yy > mxy) mxy = yy;
              end
            end
          end
          exp_cyc++;
        end
        if (blk + wht > 0 && blk * 4 >= (blk + wht) * BQ) begin
`ifdef FINDER_MIDPOINT_EN
          cx = (mnx + mxx) / 2; cy = (mny + mxy) / 2;
`else
          cx = fx; cy = fy;
`endif
          exp_cx[exp_cnt*CW +: CW] = cx[CW-1:0];
          exp_cy[exp_cnt*CW +: CW] = cy[CW-1:0];
          exp_cnt++;
          if (exp_cnt == NC) begin exp_ok = 1; fin = 1; end
        end
      end
    end
  endtask

  task automatic run(input string tag);
    int busy_len, pulse_at, lim;
    bit gv, ge;
    model();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_len = 0; pulse_at = 0; gv = 0; ge = 0; lim = exp_cyc + 8;
    got_cx = '0; got_cy = '0; got_cnt = 0;
    for (int k = 1; k <= lim && pulse_at == 0; k++) begin
      @(negedge clk);
      if (busy_out) busy_len++;
      if (centers_valid || centers_not_found_error) begin
        pulse_at = k; gv = centers_valid; ge = centers_not_found_error;
        got_cx = centers_x; got_cy = centers_y; got_cnt = int'(centers_count);
      end
    end
    got_busy = busy_len; got_err = ge;
    chk({tag, "/busy_len"}, busy_len, exp_cyc);
    chk({tag, "/pulse_cycle"}, pulse_at, exp_cyc + 1);
    chk({tag, "/valid"}, gv, exp_ok);
    chk({tag, "/error"}, ge, !exp_ok);
    chk({tag, "/count"}, got_cnt, exp_cnt);
    chk({tag, "/centers_x"}, got_cx, exp_cx);
    chk({tag, "/centers_y"}, got_cy, exp_cy);
    @(negedge clk);
    chk({tag, "/after_flags"}, {busy_out, centers_valid, centers_not_found_error}, 0);
    chk({tag, "/hold_count"}, centers_count, exp_cnt);
    chk({tag, "/hold_x"}, centers_x, exp_cx);
  endtask

  task automatic blob_setup();
    clear_all();
    set_bounds(8, 16, 7, 14);
    hf[2] = 1; hf[3] = 1; hf[19] = 1; hf[20] = 1;
    vf[2] = 1; vf[3] = 1; vf[16] = 1; vf[17] = 1;
    foreach (frame[i]) if (hf[i % W] && vf[i / W]) frame[i] = 1'b0;
  endtask

  initial begin
    int dens, a, b, t, waited;
    clear_all();
    set_bounds(8, 16, 7, 14);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy_out, centers_valid, centers_not_found_error, centers_count,
                          address_reading, centers_x, centers_y}, 0);
    rst_n = 1'b1;

    // No flags anywhere: every pixel costs one cycle, one EVAL per zone.
    run("noflags");
    chk("noflags/busy_lit", got_busy, 489);
    chk("noflags/err_lit", got_err, 1);
    chk("noflags/addr_zero", address_reading, 0);

    // Async reset while the first candidate (2,2) is being read.
    blob_setup();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    while (address_reading != AW'(2 + 2*W) && waited < 100) begin
      @(negedge clk); waited++;
    end
    chk("rst_wait/reached", waited < 100, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_wait/outputs_zero", {busy_out, centers_valid, centers_not_found_error, centers_count,
                                     address_reading, centers_x, centers_y}, 0);
    @(negedge clk); rst_n = 1'b1;

    run("blobs");
    chk("blobs/busy_lit", got_busy, 415);
    chk("blobs/cx_lit", got_cx, {5'd2, 5'd19, 5'd2});
    chk("blobs/cy_lit", got_cy, {5'd16, 5'd2, 5'd2});
    chk("blobs/count_lit", got_cnt, 3);

    clear_all();
    set_bounds(8, 8, 7, 14);
    run("empty_mid");
    chk("empty_mid/busy_lit", got_busy, 492);

    // Exactly 3 of 4 black meets a 3/4 threshold; 2 of 4 does not.
    clear_all();
    set_bounds(8, 16, 7, 14);
    hf[2] = 1; hf[3] = 1; vf[2] = 1; vf[3] = 1;
    frame[2+2*W] = 0; frame[3+2*W] = 0; frame[2+3*W] = 0;
    run("thr_3of4");
    chk("thr_3of4/count_lit", got_cnt, 1);
    chk("thr_3of4/cx_lit", got_cx, 15'd2);
    frame[2+3*W] = 1;
    run("thr_2of4");
    chk("thr_2of4/count_lit", got_cnt, 0);

    for (int r = 0; r < 25; r++) begin
      dens = $urandom_range(55, 100);
      for (int i = 0; i < W*H; i++) frame[i] = ($urandom_range(0, 99) >= dens);
      for (int i = 0; i < W; i++) hf[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < H; i++) vf[i] = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, W); b = $urandom_range(0, W);
      if (a > b) begin t = a; a = b; b = t; end
      if (r % 5 == 0) b = a;
      bxs[0] = a; bxs[1] = b;
      a = $urandom_range(0, H); b = $urandom_range(0, H);
      if (a > b) begin t = a; a = b; b = t; end
      set_bounds(bxs[0], bxs[1], a, b);
      run($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
